ms_section_sampler: RTL and testbench
=====================================

Name: ms_section_sampler

Overview:
Parametrised successor to the two-section master/slave sampler. It serves NUM_CH slave input channels, each a data word plus a sync flag. In SECTION_A it arbitrates round-robin across the channels whose sync flag is set and latches the winning sample. In SECTION_B it presents that sample to the master side for one cycle, holds for a configurable dwell, then returns to SECTION_A. It sits between slave producers and a single master consumer in the generated-system datapath.

Parameters:
DATA_W, 32, width of each channel data word and of m_out
NUM_CH, 4, number of slave channels (>=1)
HOLD_CYCLES, 2, cycles spent in SECTION_B per sample (>=1)
CNT_W, 16, width of the accepted-sample counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
s_in  input  NUM_CH*DATA_W  channel data; channel k occupies bits [k*DATA_W +: DATA_W]
s_in_sync  input  NUM_CH  per-channel sync/valid flag; bit k belongs to channel k
m_out  output  DATA_W  latched sample (val_signal)
m_out_valid  output  1  one-cycle strobe: m_out holds a new sample
m_out_ch  output  max(1,$clog2(NUM_CH))  channel index of the current m_out
section_o  output  1  0 = SECTION_A, 1 = SECTION_B
sample_cnt  output  CNT_W  number of accepted samples since reset

Behaviour:
- Reset (async, any state, mid-dwell included):
  - section = SECTION_A.
  - val_signal, m_out, m_out_ch, sample_cnt = 0; m_out_valid = 0.
  - rr_ptr = 0; hold counter = 0.
  - A sample in flight is discarded. Nothing is emitted after reset deasserts until a new grant.
- All outputs are registered; no combinational path from inputs to outputs.
- SECTION_A:
  - Each cycle, search s_in_sync starting at rr_ptr, ascending, wrapping at NUM_CH-1 -> 0.
  - First set bit wins (index g). At the clock edge:
    - val_signal <= s_in[g]; m_out_ch <= g.
    - rr_ptr <= (g+1) mod NUM_CH.
    - sample_cnt <= sample_cnt+1, wrapping modulo 2^CNT_W.
    - section <= SECTION_B; m_out_valid <= 1; hold counter <= HOLD_CYCLES-1.
  - No sync bit set: stay in A; val_signal, m_out_ch and rr_ptr are unchanged; m_out_valid = 0.
  - Latency: sync sampled at edge E -> m_out/m_out_valid visible in the cycle after E (1 cycle).
- SECTION_B:
  - m_out_valid is high only in the first B cycle and drops to 0 thereafter.
  - m_out and m_out_ch stay stable for the whole dwell and after it, until the next grant.
  - If hold counter == 0 at an edge: section <= SECTION_A. Otherwise decrement.
  - B lasts exactly HOLD_CYCLES cycles.
  - s_in_sync and s_in are ignored in B. Producers keep sync asserted until served; no sample is queued.
- Simultaneous sync on several channels: only one grant per A visit. The others are served on later A visits in round-robin order.
- Starvation bound: a channel holding sync continuously is granted within NUM_CH A-visits.
- NUM_CH=1: rr_ptr is constant 0; m_out_ch is constant 0.
- HOLD_CYCLES=1: sequence is one A cycle then one B cycle, so there is at most one grant every 2 cycles.

Test Plan:
- Reset values: assert rst mid-cycle with no clock edge -> outputs 0 and section_o=0 immediately; deassert with all sync=0 for 10 cycles -> m_out_valid stays 0 and sample_cnt=0.
- Single grant: sync=4'b0100, ch2 data=0x55 in A at edge E -> cycle after E: m_out=0x55, m_out_ch=2, m_out_valid=1, section_o=1. Next cycle: valid=0. Following cycle: section_o=0 (HOLD_CYCLES=2). sample_cnt=1.
- Round-robin: sync=4'b1111 held with data 0x10,0x11,0x12,0x13 -> grants in order ch0,ch1,ch2,ch3,ch0; valid strobes every 3 cycles; sample_cnt=5 after 5 grants.
- B-ignore: raise sync on ch1 only during a B dwell, drop it before B ends -> no grant and no valid; m_out is unchanged.
- Reset mid-dwell: assert rst in the first B cycle after grant of 0xAB -> m_out=0, section_o=0. After release, with sync=4'b0001, grant ch0 (rr_ptr restarted at 0).
- Counter wrap: CNT_W=4, run 17 grants -> sample_cnt reads 1.

Source files
------------

// File: rtl/ms_section_sampler.sv
`default_nettype none
// ============================================================================
// Module   : ms_section_sampler
// Brief    : Two-section master/slave sampler. SECTION_A picks one ready
//            slave channel round-robin and latches its word; SECTION_B shows
//            that word to the master for a fixed dwell, then returns to A.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module ms_section_sampler #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] s_in,
  input  logic [NUM_CH-1:0]        s_in_sync,
  output logic [DATA_W-1:0]        m_out,
  output logic                     m_out_valid,
  output logic [CH_W-1:0]          m_out_ch,
  output logic                     section_o,
  output logic [CNT_W-1:0]         sample_cnt
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [0:0] {
    SECTION_A = 1'b0,
    SECTION_B = 1'b1
  } section_t;

  section_t              section_q;
  section_t              section_d;
  logic                  take;
  logic [CH_W-1:0]       rr_ptr;
  logic [HC_W-1:0]       hold_cnt;
  logic [DATA_W-1:0]     val_signal;
  logic                  found;
  logic [CH_W-1:0]       grant;
  logic [DATA_W-1:0]     grant_data;
  int                    idx;

  // Round-robin search: walk the channels starting at rr_ptr, first ready wins.
  always_comb begin
    found      = 1'b0;
    grant      = '0;
    grant_data = '0;
    idx        = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!found && s_in_sync[idx]) begin
        found      = 1'b1;
        grant      = CH_W'(idx);
        grant_data = s_in[idx*DATA_W +: DATA_W];
      end
    end
  end

  // Section state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_q <= SECTION_A;
    end else begin
      section_q <= section_d;
    end
  end

  // Next section: A grants when any channel is ready; B leaves when the dwell expires.
  always_comb begin
    section_d = section_q;
    take      = 1'b0;
    case (section_q)
      SECTION_A: begin
        if (found) begin
          section_d = SECTION_B;
          take      = 1'b1;
        end
      end
      SECTION_B: begin
        if (hold_cnt == '0) begin
          section_d = SECTION_A;
        end
      end
      default: section_d = SECTION_A;
    endcase
  end

  // Sample datapath: latch on grant, advance pointer and count, run the dwell timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_signal  <= '0;
      m_out_ch    <= '0;
      m_out_valid <= 1'b0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      sample_cnt  <= '0;
    end else begin
      m_out_valid <= take;
      if (take) begin
        val_signal <= grant_data;
        m_out_ch   <= grant;
        rr_ptr     <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
        sample_cnt <= sample_cnt + CNT_W'(1);
        hold_cnt   <= HC_W'(HOLD_CYCLES - 1);
      end else if (section_q == SECTION_B && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HC_W'(1);
      end
    end
  end

  assign m_out     = val_signal;
  assign section_o = (section_q == SECTION_B);

endmodule
`default_nettype wire

// File: tb/tb_ms_section_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ms_section_sampler
// Brief    : Self-checking bench for ms_section_sampler: directed scenarios
//            with literal expectations plus randomized traffic checked every
//            cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ms_section_sampler;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int HOLD   = 2;
  localparam int CNT_W  = 4;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_CH*DATA_W-1:0] s_in = '0;
  logic [NUM_CH-1:0]        s_in_sync = '0;
  logic [DATA_W-1:0]        m_out;
  logic                     m_out_valid;
  logic [CH_W-1:0]          m_out_ch;
  logic                     section_o;
  logic [CNT_W-1:0]         sample_cnt;

  int errors = 0;
  int checks = 0;

  ms_section_sampler #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_in_sync(s_in_sync),
    .m_out(m_out), .m_out_valid(m_out_valid), .m_out_ch(m_out_ch),
    .section_o(section_o), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: dwell = number of B cycles still to run (0 means in A).
  int          mdl_dwell = 0;
  int          mdl_ptr   = 0;
  logic [31:0] mdl_data  = '0;
  int          mdl_ch    = 0;
  int          mdl_cnt   = 0;
  bit          mdl_valid = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mdl_dwell = 0; mdl_ptr = 0; mdl_data = '0;
        mdl_ch = 0; mdl_cnt = 0; mdl_valid = 1'b0;
      end else if (mdl_dwell == 0) begin
        mdl_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
          int c;
          c = (mdl_ptr + k) % NUM_CH;
          if (!mdl_valid && s_in_sync[c]) begin
            mdl_valid = 1'b1;
            mdl_data  = s_in[c*DATA_W +: DATA_W];
            mdl_ch    = c;
            mdl_ptr   = (c + 1) % NUM_CH;
            mdl_cnt   = (mdl_cnt + 1) % (1 << CNT_W);
            mdl_dwell = HOLD;
          end
        end
      end else begin
        mdl_dwell = mdl_dwell - 1;
        mdl_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_m_out",   64'(m_out),       64'(mdl_data));
      chk("cyc_valid",   64'(m_out_valid), 64'(mdl_valid));
      chk("cyc_ch",      64'(m_out_ch),    64'(mdl_ch));
      chk("cyc_section", 64'(section_o),   64'(mdl_dwell != 0));
      chk("cyc_cnt",     64'(sample_cnt),  64'(mdl_cnt));
    end
  end

  task automatic set_ch(input int c, input logic [31:0] d);
    s_in[c*DATA_W +: DATA_W] = d;
  endtask

  // Wait for a valid strobe, returning how many edges it took.
  task automatic wait_valid(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      n++;
      if (m_out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL wait_valid: got timeout expected strobe at %0t", $time);
    end
  endtask

  initial begin
    int n;
    bit ok;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: nothing emitted, counter stays 0.
    repeat (10) @(negedge clk);
    chk("idle_valid", 64'(m_out_valid), 64'd0);
    chk("idle_cnt",   64'(sample_cnt),  64'd0);

    // Single grant on channel 2.
    set_ch(2, 32'h55);
    s_in_sync = 4'b0100;
    @(posedge clk); #1;
    chk("single_data",    64'(m_out),       64'h55);
    chk("single_ch",      64'(m_out_ch),    64'd2);
    chk("single_valid",   64'(m_out_valid), 64'd1);
    chk("single_section", 64'(section_o),   64'd1);
    chk("single_cnt",     64'(sample_cnt),  64'd1);
    s_in_sync = '0;
    @(posedge clk); #1;
    chk("single_valid2",  64'(m_out_valid), 64'd0);
    chk("single_sec2",    64'(section_o),   64'd1);
    @(posedge clk); #1;
    chk("single_sec3",    64'(section_o),   64'd0);
    chk("single_hold",    64'(m_out),       64'h55);

    // Asynchronous reset between edges clears outputs immediately.
    #2 rst = 1'b1;
    #1;
    chk("arst_m_out",   64'(m_out),     64'd0);
    chk("arst_section", 64'(section_o), 64'd0);
    chk("arst_ch",      64'(m_out_ch),  64'd0);
    chk("arst_cnt",     64'(sample_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Round-robin with all channels ready.
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 32'h10 + c);
    s_in_sync = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_valid(n, ok);
      if (ok) begin
        chk("rr_ch",   64'(m_out_ch), 64'(g % 4));
        chk("rr_data", 64'(m_out),    64'(32'h10 + (g % 4)));
        if (g > 0) chk("rr_spacing", 64'(n), 64'd3);
      end
    end
    chk("rr_cnt", 64'(sample_cnt), 64'd5);
    s_in_sync = '0;
    repeat (4) @(negedge clk);

    // Sync raised only inside a B dwell is ignored.
    set_ch(0, 32'h77);
    s_in_sync = 4'b0001;
    wait_valid(n, ok);
    set_ch(1, 32'hEE);
    s_in_sync = 4'b0010;
    @(posedge clk); #1;
    s_in_sync = '0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("bign_valid", 64'(m_out_valid), 64'd0);
      chk("bign_data",  64'(m_out),       64'h77);
    end

    // Reset in the first B cycle discards the sample; pointer restarts at 0.
    set_ch(0, 32'hAB);
    s_in_sync = 4'b0001;
    wait_valid(n, ok);
    chk("mid_pre", 64'(m_out), 64'hAB);
    rst = 1'b1;
    #1;
    chk("mid_m_out",   64'(m_out),     64'd0);
    chk("mid_section", 64'(section_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) set_ch(c, 32'hC0 + c);
    s_in_sync = 4'b1111;
    wait_valid(n, ok);
    chk("mid_regrant_ch", 64'(m_out_ch), 64'd0);
    chk("mid_regrant_d",  64'(m_out),    64'hC0);

    // Counter wraps modulo 2^CNT_W: 17 grants from reset leaves 1.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int g = 0; g < 17; g++) wait_valid(n, ok);
    chk("wrap_cnt", 64'(sample_cnt), 64'd1);
    s_in_sync = '0;

    // Randomized traffic with occasional resets, checked every cycle.
    for (int t = 0; t < 600; t++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(0, 79) == 0);
      s_in_sync = NUM_CH'($urandom & $urandom);
      for (int c = 0; c < NUM_CH; c++) set_ch(c, $urandom);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    s_in_sync = '0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
